axil2native_adapter: RTL and testbench
======================================

# axil2native_adapter

AXI4-Lite slave to native-bus master bridge. It accepts AXI4-Lite read and write transactions from an external master, buffers each channel, and replays each transaction as one native request (valid/addr/wdata/wstrb held until ready). It then returns the B or R response. It sits between an AXI4-Lite interconnect and native-bus peripherals or memories.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- s_axi_awvalid/awready  in/out  1  write-address handshake; s_axi_awaddr in ADDR_WIDTH; s_axi_awprot in 3 (ignored)
- s_axi_wvalid/wready  in/out  1  write-data handshake; s_axi_wdata in DATA_WIDTH; s_axi_wstrb in STRB_WIDTH
- s_axi_bvalid/bready  out/in  1  write response; s_axi_bresp out 2
- s_axi_arvalid/arready  in/out  1  read-address handshake; s_axi_araddr in ADDR_WIDTH; s_axi_arprot in 3 (bit 2 = instruction)
- s_axi_rvalid/rready  out/in  1  read response; s_axi_rdata out DATA_WIDTH; s_axi_rresp out 2
- native_valid  out  1  request valid, held until native_ready
- native_instr  out  1  instruction fetch (reads only)
- native_ready  in  1  one-cycle completion pulse from slave
- native_addr  out  ADDR_WIDTH  request address
- native_wdata  out  DATA_WIDTH  write data
- native_wstrb  out  STRB_WIDTH  byte enables; all-zero means read
- native_rdata  in  DATA_WIDTH  read data, valid when native_ready

## Operation
- Three channel buffers: AW (addr, full flag aw_full), W (data+strb, w_full), AR (addr+prot[2], ar_full). awready=!aw_full, wready=!w_full, arready=!ar_full, all forced 0 while resetn low. Handshake sets flag and loads buffer; AW and W accepted independently, any order.
- FSM states: IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP.
- IDLE: write pending = aw_full&&w_full; read pending = ar_full. Only one pending -> serve it. Both -> serve per prio_write (reset 1). Granting a write clears prio_write; granting a read sets it.
- Write grant with nonzero wstrb -> WR_REQ. Write with wstrb==0 -> WR_RESP directly; no native access.
- WR_REQ: native_valid=1, addr/wdata/wstrb from buffers, native_instr=0. On native_ready -> WR_RESP.
- RD_REQ: native_valid=1, addr from AR buffer, native_wstrb=0, native_instr=arprot[2]. On native_ready capture native_rdata into rdata register -> RD_RESP.
- WR_RESP: bvalid=1, bresp=2'b00. On bready clear aw_full and w_full -> IDLE.
- RD_RESP: rvalid=1, rresp=2'b00, rdata from register, stable. On rready clear ar_full -> IDLE.
- Native outputs are registered from buffers/state; no combinational path from any AXI input to native outputs or vice versa.
- native_ready outside WR_REQ/RD_REQ ignored.

## Timing
- Reset values: FSM=IDLE, all full flags 0, prio_write=1, native_valid=0, native_wstrb=0, native_instr=0, bvalid=0, rvalid=0, rdata reg=0, resp=0.
- Write latency: AW+W handshake at edge 0 -> native_valid high cycle 2 -> native_ready same cycle -> bvalid cycle 3 -> bready cycle 3 -> awready/wready high cycle 4.
- Read latency: AR handshake edge 0 -> native_valid cycle 2 -> rvalid cycle after native_ready.
- native_valid drops in the cycle after native_ready; addr/wdata/wstrb/instr stable for the whole request.
- bvalid/rvalid held until ready; a stalled response stalls the FSM (no new native request), other channels may still fill.
- A second AR may be accepted while a write is in flight only if ar_full=0; no more than one transaction per channel buffered.
- resetn low mid-request: all state cleared next edge, native_valid=0, in-flight native access abandoned, no response issued.

## Test plan
- Single write addr 0x10, data 0xDEADBEEF, strb 0xF, native_ready 3 cycles after native_valid -> one native write with those values, bvalid 1 cycle after native_ready, bresp=0.
- W presented 5 cycles before AW -> wready drops after W accepted, native request only after AW accepted, same addr/data.
- Read addr 0x20, arprot=3'b100, slave returns 0x12345678 -> native_wstrb=0, native_instr=1, rdata=0x12345678 held while rready=0 for 4 cycles.
- Write and read pending same cycle, repeated twice -> order write, read, write, read (alternating priority).
- Write with wstrb=0 -> no native_valid, bvalid 1 cycle after grant, bresp=0.
- resetn asserted during RD_REQ -> native_valid=0, all ready outputs 0 in reset, rvalid never asserted; next read completes normally.

Source files
------------

// File: rtl/axil2native_adapter.sv
// AXI4-Lite slave to native-bus master bridge.
// Each AXI channel has a one-entry buffer; a small FSM replays one buffered
// transaction at a time as a native request and then returns the B or R response.
// state   | meaning
// IDLE    | waiting for a complete write (AW+W) or a read (AR)
// WR_REQ  | native write request outstanding
// RD_REQ  | native read request outstanding
// WR_RESP | bvalid asserted, waiting for bready
// RD_RESP | rvalid asserted, waiting for rready
module axil2native_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  native_valid,
    output logic                  native_instr,
    input  logic                  native_ready,
    output logic [ADDR_WIDTH-1:0] native_addr,
    output logic [DATA_WIDTH-1:0] native_wdata,
    output logic [STRB_WIDTH-1:0] native_wstrb,
    input  logic [DATA_WIDTH-1:0] native_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        WR_RESP = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_aw_full;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_full;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_WIDTH-1:0] r_w_strb;
    logic                  r_ar_full;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic                  r_ar_instr;
    logic                  r_prio_write;
    logic                  r_native_valid;
    logic [ADDR_WIDTH-1:0] r_native_addr;
    logic [DATA_WIDTH-1:0] r_native_wdata;
    logic [STRB_WIDTH-1:0] r_native_wstrb;
    logic                  r_native_instr;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_wr_pend;
    logic w_rd_pend;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_native_done;
    logic w_b_done;
    logic w_r_done;
    logic w_unused_prot;

    // Only the instruction bit of arprot carries meaning on the native side.
    assign w_unused_prot = ^{s_axi_awprot, s_axi_arprot[1:0]};

    assign s_axi_awready = resetn && !r_aw_full;
    assign s_axi_wready  = resetn && !r_w_full;
    assign s_axi_arready = resetn && !r_ar_full;

    assign w_wr_pend     = r_aw_full && r_w_full;
    assign w_rd_pend     = r_ar_full;
    // native_ready is only meaningful while our request is actually on the bus
    assign w_native_done = r_native_valid && native_ready;
    assign w_b_done      = (r_state == WR_RESP) && s_axi_bready;
    assign w_r_done      = (r_state == RD_RESP) && s_axi_rready;

    assign s_axi_bvalid  = (r_state == WR_RESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = (r_state == RD_RESP);
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = r_rdata;

    assign native_valid  = r_native_valid;
    assign native_addr   = r_native_addr;
    assign native_wdata  = r_native_wdata;
    assign native_wstrb  = r_native_wstrb;
    assign native_instr  = r_native_instr;

    // Channel buffers: a handshake fills the entry, response acceptance frees it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_aw_full  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_ar_full  <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_instr <= 1'b0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= s_axi_awaddr;
            end else if (w_b_done) begin
                r_aw_full <= 1'b0;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                r_w_full <= 1'b1;
                r_w_data <= s_axi_wdata;
                r_w_strb <= s_axi_wstrb;
            end else if (w_b_done) begin
                r_w_full <= 1'b0;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                r_ar_full  <= 1'b1;
                r_ar_addr  <= s_axi_araddr;
                r_ar_instr <= s_axi_arprot[2];
            end else if (w_r_done) begin
                r_ar_full <= 1'b0;
            end
        end
    end

    // State register and round-robin priority between writes and reads.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_prio_write <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_grant_wr) begin
                r_prio_write <= 1'b0;
            end else if (w_grant_rd) begin
                r_prio_write <= 1'b1;
            end
        end
    end

    // Arbitration and next-state decode.
    always_comb begin
        w_next     = r_state;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_pend && (!w_rd_pend || r_prio_write)) begin
                    w_grant_wr = 1'b1;
                    // a write with no byte enables touches nothing; answer it directly
                    w_next     = (|r_w_strb) ? WR_REQ : WR_RESP;
                end else if (w_rd_pend) begin
                    w_grant_rd = 1'b1;
                    w_next     = RD_REQ;
                end
            end
            WR_REQ:  if (w_native_done) w_next = WR_RESP;
            RD_REQ:  if (w_native_done) w_next = RD_RESP;
            WR_RESP: if (s_axi_bready)  w_next = IDLE;
            RD_RESP: if (s_axi_rready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Native request: launched one cycle after entering a REQ state, held until ready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_native_valid <= 1'b0;
            r_native_addr  <= '0;
            r_native_wdata <= '0;
            r_native_wstrb <= '0;
            r_native_instr <= 1'b0;
        end else if (r_native_valid) begin
            if (native_ready) r_native_valid <= 1'b0;
        end else if (r_state == WR_REQ) begin
            r_native_valid <= 1'b1;
            r_native_addr  <= r_aw_addr;
            r_native_wdata <= r_w_data;
            r_native_wstrb <= r_w_strb;
            r_native_instr <= 1'b0;
        end else if (r_state == RD_REQ) begin
            r_native_valid <= 1'b1;
            r_native_addr  <= r_ar_addr;
            r_native_wstrb <= '0;
            r_native_instr <= r_ar_instr;
        end
    end

    // Read data capture; held stable for the whole R phase.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if ((r_state == RD_REQ) && w_native_done) begin
            r_rdata <= native_rdata;
        end
    end

endmodule

// File: tb/tb_axil2native_adapter.sv
// Directed bench for axil2native_adapter with hand-computed expectations.
module tb_axil2native_adapter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        native_valid, native_instr, native_ready;
    logic [31:0] native_addr, native_wdata, native_rdata;
    logic [3:0]  native_wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil2native_adapter dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .native_valid(native_valid), .native_instr(native_instr),
        .native_ready(native_ready), .native_addr(native_addr),
        .native_wdata(native_wdata), .native_wstrb(native_wstrb),
        .native_rdata(native_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Acts as native slave and AXI response acceptor for one transaction.
    task automatic serve(output logic is_wr);
        int n;
        n = 0;
        while (!native_valid && n < 20) begin step; n++; end
        chk("serve_native_valid", native_valid, 1);
        is_wr = |native_wstrb;
        native_rdata = 32'h0BAD_F00D;
        native_ready = 1'b1;
        step;
        native_ready = 1'b0;
        n = 0;
        while (!(s_axi_bvalid || s_axi_rvalid) && n < 20) begin step; n++; end
        chk("serve_resp_seen", s_axi_bvalid || s_axi_rvalid, 1);
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        step;
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        logic o1, o2;
        resetn = 1'b0;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awprot = 0;
        s_axi_wvalid = 0;  s_axi_wdata = 0;  s_axi_wstrb = 0;
        s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arprot = 0;
        s_axi_rready = 0;
        native_ready = 0;  native_rdata = 0;
        step; step;
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_arready", s_axi_arready, 0);
        resetn = 1'b1;
        step;
        chk("idle_awready", s_axi_awready, 1);
        chk("idle_wready", s_axi_wready, 1);
        chk("idle_arready", s_axi_arready, 1);
        chk("idle_nvalid", native_valid, 0);
        chk("idle_nwstrb", native_wstrb, 0);
        chk("idle_ninstr", native_instr, 0);
        chk("idle_bvalid", s_axi_bvalid, 0);
        chk("idle_rvalid", s_axi_rvalid, 0);
        chk("idle_rdata", s_axi_rdata, 0);

        // single write, ready 3 cycles after valid
        s_axi_awvalid = 1; s_axi_awaddr = 32'h10;
        s_axi_wvalid = 1;  s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
        step;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        chk("w1_awready_full", s_axi_awready, 0);
        chk("w1_wready_full", s_axi_wready, 0);
        chk("w1_nvalid_c0", native_valid, 0);
        step;
        chk("w1_nvalid_c1", native_valid, 0);
        step;
        chk("w1_nvalid_c2", native_valid, 1);
        chk("w1_naddr", native_addr, 32'h10);
        chk("w1_nwdata", native_wdata, 32'hDEADBEEF);
        chk("w1_nwstrb", native_wstrb, 4'hF);
        chk("w1_ninstr", native_instr, 0);
        step; step;
        chk("w1_nvalid_hold", native_valid, 1);
        chk("w1_naddr_hold", native_addr, 32'h10);
        chk("w1_bvalid_early", s_axi_bvalid, 0);
        step;
        native_ready = 1;
        step;
        native_ready = 0;
        chk("w1_nvalid_drop", native_valid, 0);
        chk("w1_bvalid", s_axi_bvalid, 1);
        chk("w1_bresp", s_axi_bresp, 0);
        step;
        chk("w1_bvalid_hold", s_axi_bvalid, 1);
        chk("w1_awready_stall", s_axi_awready, 0);
        s_axi_bready = 1;
        step;
        s_axi_bready = 0;
        chk("w1_bvalid_done", s_axi_bvalid, 0);
        chk("w1_awready_free", s_axi_awready, 1);
        chk("w1_wready_free", s_axi_wready, 1);

        // W five cycles ahead of AW
        s_axi_wvalid = 1; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'h3;
        step;
        s_axi_wvalid = 0;
        chk("w2_wready_drop", s_axi_wready, 0);
        step; step; step; step;
        chk("w2_nvalid_noaw", native_valid, 0);
        chk("w2_awready", s_axi_awready, 1);
        s_axi_awvalid = 1; s_axi_awaddr = 32'h44;
        step;
        s_axi_awvalid = 0;
        step; step;
        chk("w2_nvalid", native_valid, 1);
        chk("w2_naddr", native_addr, 32'h44);
        chk("w2_nwdata", native_wdata, 32'hCAFEF00D);
        chk("w2_nwstrb", native_wstrb, 4'h3);
        native_ready = 1;
        step;
        native_ready = 0;
        chk("w2_bvalid", s_axi_bvalid, 1);
        s_axi_bready = 1;
        step;
        s_axi_bready = 0;
        chk("w2_bvalid_done", s_axi_bvalid, 0);

        // instruction read with stalled R channel
        s_axi_arvalid = 1; s_axi_araddr = 32'h20; s_axi_arprot = 3'b100;
        step;
        s_axi_arvalid = 0;
        chk("r1_arready_full", s_axi_arready, 0);
        step; step;
        chk("r1_nvalid", native_valid, 1);
        chk("r1_naddr", native_addr, 32'h20);
        chk("r1_nwstrb", native_wstrb, 0);
        chk("r1_ninstr", native_instr, 1);
        native_rdata = 32'h12345678; native_ready = 1;
        step;
        native_ready = 0; native_rdata = 32'hFFFFFFFF;
        chk("r1_nvalid_drop", native_valid, 0);
        for (int i = 0; i < 4; i++) begin
            chk("r1_rvalid_hold", s_axi_rvalid, 1);
            chk("r1_rdata_hold", s_axi_rdata, 32'h12345678);
            chk("r1_rresp", s_axi_rresp, 0);
            step;
        end
        s_axi_rready = 1;
        step;
        s_axi_rready = 0;
        chk("r1_rvalid_done", s_axi_rvalid, 0);
        chk("r1_arready_free", s_axi_arready, 1);

        // write and read pending together, twice: write, read, write, read
        for (int r = 0; r < 2; r++) begin
            s_axi_awvalid = 1; s_axi_awaddr = 32'h100 + r;
            s_axi_wvalid = 1;  s_axi_wdata = 32'h1111 * (r + 1); s_axi_wstrb = 4'h1;
            s_axi_arvalid = 1; s_axi_araddr = 32'h200 + r; s_axi_arprot = 3'b000;
            step;
            s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
            serve(o1);
            serve(o2);
            chk("prio_first_is_write", o1, 1);
            chk("prio_second_is_read", o2, 0);
        end

        // zero-strobe write: response without native access
        s_axi_awvalid = 1; s_axi_awaddr = 32'h80;
        s_axi_wvalid = 1;  s_axi_wdata = 32'h55; s_axi_wstrb = 4'h0;
        step;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        chk("z_nvalid_c0", native_valid, 0);
        chk("z_bvalid_c0", s_axi_bvalid, 0);
        step;
        chk("z_nvalid_c1", native_valid, 0);
        chk("z_bvalid_c1", s_axi_bvalid, 1);
        chk("z_bresp", s_axi_bresp, 0);
        s_axi_bready = 1;
        step;
        s_axi_bready = 0;
        chk("z_nvalid_after", native_valid, 0);
        chk("z_bvalid_done", s_axi_bvalid, 0);

        // reset during RD_REQ
        s_axi_arvalid = 1; s_axi_araddr = 32'h30; s_axi_arprot = 3'b000;
        step;
        s_axi_arvalid = 0;
        step; step;
        chk("rr_nvalid_before", native_valid, 1);
        resetn = 0;
        #1;
        chk("rr_awready_in_rst", s_axi_awready, 0);
        chk("rr_wready_in_rst", s_axi_wready, 0);
        chk("rr_arready_in_rst", s_axi_arready, 0);
        step;
        chk("rr_nvalid_cleared", native_valid, 0);
        chk("rr_rvalid_in_rst", s_axi_rvalid, 0);
        resetn = 1;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("rr_rvalid_never", s_axi_rvalid, 0);
            chk("rr_nvalid_idle", native_valid, 0);
        end
        chk("rr_arready_after", s_axi_arready, 1);
        s_axi_arvalid = 1; s_axi_araddr = 32'h34; s_axi_arprot = 3'b000;
        step;
        s_axi_arvalid = 0;
        step; step;
        chk("rr2_nvalid", native_valid, 1);
        chk("rr2_naddr", native_addr, 32'h34);
        chk("rr2_ninstr", native_instr, 0);
        native_rdata = 32'hA5A55A5A; native_ready = 1;
        step;
        native_ready = 0;
        chk("rr2_rvalid", s_axi_rvalid, 1);
        chk("rr2_rdata", s_axi_rdata, 32'hA5A55A5A);
        s_axi_rready = 1;
        step;
        s_axi_rready = 0;
        chk("rr2_rvalid_done", s_axi_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
